// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: round-robin arbiter between the SUBNEG core and the host
// loader for the shared 8-bit multiplexed SRAM bus. Sequences the address
// latch, OE/WE strobes and the output latch for one byte transfer at a time.
// Every output is a register loaded from the value implied by the state being
// entered, so each state's outputs are visible for the whole cycle it is active.
module sram_bus_arbiter #(
    parameter logic [7:0]  OUT_ADDR  = 8'hFF,
    parameter int unsigned RD_WAIT   = 1,
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       core_req,
    input  logic       core_we,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_wdata,
    output logic       core_ack,
    output logic [7:0] core_rdata,

    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,

    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,

    output logic       mem_latch_clk,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic       out_latch_clk,

    output logic       busy,
    output logic       grant_host
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_RD,
        S_WDATA,
        S_WR,
        S_OUTP,
        S_DONE
    } state_t;

    // Cycle counters load "length - 1" and the state exits when they hit zero.
    localparam logic [2:0] RD_CNT_INIT = 3'(RD_WAIT - 1);
    localparam logic [2:0] WR_CNT_INIT = 3'(WE_CYCLES - 1);

    state_t     state_q, state_d;
    // last_host_q doubles as the owner of the transaction in flight: it is
    // updated on every grant and holds until the next one.
    logic       last_host_q, last_host_d;
    logic [7:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [2:0] cnt_q, cnt_d;

    logic [7:0] bus_out_q, bus_out_d;
    logic       bus_oe_q, bus_oe_d;
    logic       latch_clk_q, latch_clk_d;
    logic       oe_n_q, oe_n_d;
    logic       we_n_q, we_n_d;
    logic       out_clk_q, out_clk_d;
    logic       busy_q, busy_d;
    logic       grant_host_q, grant_host_d;
    logic       core_ack_q, core_ack_d;
    logic       host_ack_q, host_ack_d;
    logic [7:0] core_rdata_q, core_rdata_d;
    logic [7:0] host_rdata_q, host_rdata_d;

    // Next-state logic: arbitration and capture in IDLE, then the bus sequence.
    always_comb begin
        state_d      = state_q;
        last_host_d  = last_host_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (core_req || host_req) begin
                    // Host wins when alone, or on a tie when the core went last.
                    last_host_d = host_req && (!core_req || !last_host_q);
                    addr_d      = last_host_d ? host_addr  : core_addr;
                    we_d        = last_host_d ? host_we    : core_we;
                    wdata_d     = last_host_d ? host_wdata : core_wdata;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if (we_q) begin
                    state_d = S_WDATA;
                end else begin
                    state_d = S_RD;
                    cnt_d   = RD_CNT_INIT;
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (last_host_q) begin
                        host_rdata_d = bus_in;
                    end else begin
                        core_rdata_d = bus_in;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WDATA: begin
                if (addr_q == OUT_ADDR) begin
                    state_d = S_OUTP;
                end else begin
                    state_d = S_WR;
                    cnt_d   = WR_CNT_INIT;
                end
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_OUTP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered; bus_out holds unless reloaded.
    always_comb begin
        bus_out_d    = bus_out_q;
        bus_oe_d     = 1'b1;
        latch_clk_d  = 1'b0;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        out_clk_d    = 1'b0;
        busy_d       = (state_d != S_IDLE);
        grant_host_d = busy_d && last_host_d;
        core_ack_d   = 1'b0;
        host_ack_d   = 1'b0;

        case (state_d)
            S_ADDR: begin
                bus_out_d = addr_d;
            end
            S_LATCH: begin
                latch_clk_d = 1'b1;
            end
            S_RD: begin
                oe_n_d   = 1'b0;
                bus_oe_d = 1'b0;
            end
            S_WDATA: begin
                bus_out_d = wdata_d;
            end
            S_WR: begin
                we_n_d = 1'b0;
            end
            S_OUTP: begin
                out_clk_d = 1'b1;
            end
            S_DONE: begin
                // After a read the pads stay released for one turnaround cycle.
                bus_oe_d   = we_d;
                core_ack_d = !last_host_d;
                host_ack_d = last_host_d;
            end
            default: begin
            end
        endcase
    end

    // State register and captured transaction context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_host_q <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_host_q <= last_host_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Registered bus, strobe, ack and read-data outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_out_q    <= '0;
            bus_oe_q     <= 1'b1;
            latch_clk_q  <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            out_clk_q    <= 1'b0;
            busy_q       <= 1'b0;
            grant_host_q <= 1'b0;
            core_ack_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            bus_out_q    <= bus_out_d;
            bus_oe_q     <= bus_oe_d;
            latch_clk_q  <= latch_clk_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            out_clk_q    <= out_clk_d;
            busy_q       <= busy_d;
            grant_host_q <= grant_host_d;
            core_ack_q   <= core_ack_d;
            host_ack_q   <= host_ack_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus_out       = bus_out_q;
    assign bus_oe        = bus_oe_q;
    assign mem_latch_clk = latch_clk_q;
    assign mem_oe_n      = oe_n_q;
    assign mem_we_n      = we_n_q;
    assign out_latch_clk = out_clk_q;
    assign busy          = busy_q;
    assign grant_host    = grant_host_q;
    assign core_ack      = core_ack_q;
    assign host_ack      = host_ack_q;
    assign core_rdata    = core_rdata_q;
    assign host_rdata    = host_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: two instances (default timing and
// RD_WAIT=3/WE_CYCLES=2), each attached to a behavioural SRAM on its pads.
// Expected values come from a reference memory updated per completed write and
// from the transaction latency rules.
module tb_sram_bus_arbiter;

    localparam int         NDUT = 2;
    localparam logic [7:0] OUTA = 8'hFF;

    int rdw [NDUT] = '{1, 3};
    int wec [NDUT] = '{1, 2};

    logic clk = 1'b0;
    logic reset;

    logic       c_req   [NDUT];
    logic       c_we    [NDUT];
    logic [7:0] c_addr  [NDUT];
    logic [7:0] c_wdata [NDUT];
    logic       c_ack   [NDUT];
    logic [7:0] c_rdata [NDUT];
    logic       h_req   [NDUT];
    logic       h_we    [NDUT];
    logic [7:0] h_addr  [NDUT];
    logic [7:0] h_wdata [NDUT];
    logic       h_ack   [NDUT];
    logic [7:0] h_rdata [NDUT];
    logic [7:0] b_out   [NDUT];
    logic       b_oe    [NDUT];
    logic [7:0] b_in    [NDUT];
    logic       m_lclk  [NDUT];
    logic       m_oe_n  [NDUT];
    logic       m_we_n  [NDUT];
    logic       o_lclk  [NDUT];
    logic       busy    [NDUT];
    logic       gh      [NDUT];

    int nchk = 0;
    int nerr = 0;

    logic [7:0] smem     [NDUT][256];
    logic [7:0] refm     [NDUT][256];
    logic [7:0] lat_addr [NDUT];
    logic       prev_lclk[NDUT];
    logic [7:0] prev_bo  [NDUT];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUT_ADDR(OUTA)) u0 (
        .clk(clk), .reset(reset),
        .core_req(c_req[0]), .core_we(c_we[0]), .core_addr(c_addr[0]),
        .core_wdata(c_wdata[0]), .core_ack(c_ack[0]), .core_rdata(c_rdata[0]),
        .host_req(h_req[0]), .host_we(h_we[0]), .host_addr(h_addr[0]),
        .host_wdata(h_wdata[0]), .host_ack(h_ack[0]), .host_rdata(h_rdata[0]),
        .bus_out(b_out[0]), .bus_oe(b_oe[0]), .bus_in(b_in[0]),
        .mem_latch_clk(m_lclk[0]), .mem_oe_n(m_oe_n[0]), .mem_we_n(m_we_n[0]),
        .out_latch_clk(o_lclk[0]), .busy(busy[0]), .grant_host(gh[0])
    );

    sram_bus_arbiter #(.OUT_ADDR(OUTA), .RD_WAIT(3), .WE_CYCLES(2)) u1 (
        .clk(clk), .reset(reset),
        .core_req(c_req[1]), .core_we(c_we[1]), .core_addr(c_addr[1]),
        .core_wdata(c_wdata[1]), .core_ack(c_ack[1]), .core_rdata(c_rdata[1]),
        .host_req(h_req[1]), .host_we(h_we[1]), .host_addr(h_addr[1]),
        .host_wdata(h_wdata[1]), .host_ack(h_ack[1]), .host_rdata(h_rdata[1]),
        .bus_out(b_out[1]), .bus_oe(b_oe[1]), .bus_in(b_in[1]),
        .mem_latch_clk(m_lclk[1]), .mem_oe_n(m_oe_n[1]), .mem_we_n(m_we_n[1]),
        .out_latch_clk(o_lclk[1]), .busy(busy[1]), .grant_host(gh[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural SRAM on each instance's pads: latch address on the latch
    // clock rising, write while WE is low, drive data while OE is low.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                if (m_lclk[d] && !prev_lclk[d]) lat_addr[d] = b_out[d];
                if (!m_we_n[d]) smem[d][lat_addr[d]] = b_out[d];
                prev_lclk[d] = m_lclk[d];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NDUT; d++) begin
            b_in[d] = !m_oe_n[d] ? smem[d][lat_addr[d]] : 8'hA5;
        end
    end

    // Per-cycle bus invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("oe_we_excl", 32'(!m_oe_n[d] && !m_we_n[d]), 32'd0);
                chk("drive_while_oe", 32'(b_oe[d] && !m_oe_n[d]), 32'd0);
                chk("ack_excl", 32'(c_ack[d] && h_ack[d]), 32'd0);
                if (!m_we_n[d]) chk("we_bus_stable", 32'(b_out[d]), 32'(prev_bo[d]));
                prev_bo[d] = b_out[d];
            end
        end
    end

    task automatic preload(input int d, input logic [7:0] a, input logic [7:0] v);
        smem[d][a] = v;
        refm[d][a] = v;
    endtask

    // One transaction on instance d; cycle 0 is the IDLE cycle sampling req.
    task automatic run_txn(input int d, input bit host, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        int k, lat, exp_lat, we_first, we_cnt, lclk_first, ol_first, oe_first, oe_cnt;
        logic [7:0] ol_bus, rd, bo1, bo2, bo_ack;
        logic gh1, gh_ack;
        bit acked, other;
        k = 0; lat = -1; we_first = -1; we_cnt = 0; lclk_first = -1; ol_first = -1;
        oe_first = -1; oe_cnt = 0; acked = 0; other = 0;
        ol_bus = '0; rd = '0; bo1 = '0; bo2 = '0; bo_ack = '0; gh1 = 1'b0; gh_ack = 1'b0;
        @(posedge clk); #1;
        if (host) begin
            h_req[d] = 1'b1; h_we[d] = we; h_addr[d] = addr; h_wdata[d] = wdata;
        end else begin
            c_req[d] = 1'b1; c_we[d] = we; c_addr[d] = addr; c_wdata[d] = wdata;
        end
        while (!acked && k < 40) begin
            @(negedge clk);
            if (k == 0) chk("start_idle", 32'(busy[d]), 32'd0);
            if (k == 1) begin
                gh1 = gh[d]; bo1 = b_out[d];
                // Captured request: later input changes must be ignored.
                c_we[d] = 1'($urandom); c_addr[d] = 8'($urandom); c_wdata[d] = 8'($urandom);
                h_we[d] = 1'($urandom); h_addr[d] = 8'($urandom); h_wdata[d] = 8'($urandom);
            end
            if (k == 2) bo2 = b_out[d];
            if (!m_we_n[d]) begin if (we_first < 0) we_first = k; we_cnt++; end
            if (!b_oe[d]) begin if (oe_first < 0) oe_first = k; oe_cnt++; end
            if (m_lclk[d] && lclk_first < 0) lclk_first = k;
            if (o_lclk[d] && ol_first < 0) begin ol_first = k; ol_bus = b_out[d]; end
            if (host ? c_ack[d] : h_ack[d]) other = 1;
            if (host ? h_ack[d] : c_ack[d]) begin
                acked = 1; lat = k; rd = host ? h_rdata[d] : c_rdata[d];
                bo_ack = b_out[d]; gh_ack = gh[d];
            end
            k++;
        end
        @(posedge clk); #1;
        c_req[d] = 1'b0; h_req[d] = 1'b0;

        exp_lat = we ? ((addr == OUTA) ? 5 : 4 + wec[d]) : 3 + rdw[d];
        chk("ack_latency", lat, exp_lat);
        chk("other_ack", 32'(other), 32'd0);
        chk("latch_clk_cycle", lclk_first, 2);
        chk("grant_host_c1", 32'(gh1), 32'(host));
        chk("grant_host_ack", 32'(gh_ack), 32'(host));
        chk("bus_addr_c1", 32'(bo1), 32'(addr));
        chk("bus_addr_c2", 32'(bo2), 32'(addr));
        if (!we) begin
            chk("rdata", 32'(rd), 32'(refm[d][addr]));
            chk("bus_oe_low_first", oe_first, 3);
            chk("bus_oe_low_cnt", oe_cnt, rdw[d] + 1);
        end else begin
            chk("bus_wdata_ack", 32'(bo_ack), 32'(wdata));
            chk("bus_oe_low_cnt_w", oe_cnt, 0);
            if (addr == OUTA) begin
                chk("outp_cycle", ol_first, 4);
                chk("outp_data", 32'(ol_bus), 32'(wdata));
                chk("outp_no_we", we_cnt, 0);
            end else begin
                chk("we_first", we_first, 4);
                chk("we_width", we_cnt, wec[d]);
                chk("no_outp", ol_first, -1);
                refm[d][addr] = wdata;
            end
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy[d]), 32'd0);
        chk("idle_bus_oe", 32'(b_oe[d]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nack, r;
        logic [7:0] ra, v;

        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            c_req[d] = 1'b0; c_we[d] = 1'b0; c_addr[d] = '0; c_wdata[d] = '0;
            h_req[d] = 1'b0; h_we[d] = 1'b0; h_addr[d] = '0; h_wdata[d] = '0;
            lat_addr[d] = '0; prev_lclk[d] = 1'b0; prev_bo[d] = '0;
            for (int i = 0; i < 256; i++) begin
                v = 8'($urandom);
                smem[d][i] = v;
                refm[d][i] = v;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset values.
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_grant_host", 32'(gh[d]), 32'd0);
            chk("rst_bus_out", 32'(b_out[d]), 32'd0);
            chk("rst_bus_oe", 32'(b_oe[d]), 32'd1);
            chk("rst_latch_clk", 32'(m_lclk[d]), 32'd0);
            chk("rst_oe_n", 32'(m_oe_n[d]), 32'd1);
            chk("rst_we_n", 32'(m_we_n[d]), 32'd1);
            chk("rst_out_clk", 32'(o_lclk[d]), 32'd0);
            chk("rst_acks", 32'({c_ack[d], h_ack[d]}), 32'd0);
            chk("rst_rdata", 32'({c_rdata[d], h_rdata[d]}), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases on the default-timing instance.
        preload(0, 8'h10, 8'h5A);
        run_txn(0, 1'b0, 1'b0, 8'h10, 8'h00);
        run_txn(0, 1'b1, 1'b1, 8'h20, 8'hC3);
        run_txn(0, 1'b0, 1'b1, OUTA, 8'h77);
        run_txn(0, 1'b1, 1'b0, 8'h20, 8'h00);
        run_txn(0, 1'b0, 1'b0, OUTA, 8'h00);

        // Both requesters held high from reset; reset wins over the requests
        // in the same cycle, core wins the first tie, then strict alternation.
        @(posedge clk); #1;
        reset = 1'b1;
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h30;
        h_req[0] = 1'b1; h_we[0] = 1'b0; h_addr[0] = 8'h31;
        @(posedge clk); #1;
        reset = 1'b0;
        nack = 0; k = 0;
        while (nack < 4 && k < 60) begin
            @(negedge clk);
            if (c_ack[0] || h_ack[0]) begin
                chk("tie_ack_cycle", k, 4 + 5 * nack);
                chk("tie_winner", 32'(h_ack[0]), nack % 2);
                chk("tie_rdata", 32'(h_ack[0] ? h_rdata[0] : c_rdata[0]),
                    32'(h_ack[0] ? refm[0][8'h31] : refm[0][8'h30]));
                nack++;
            end
            k++;
        end
        chk("tie_ack_count", nack, 4);
        @(posedge clk); #1;
        c_req[0] = 1'b0; h_req[0] = 1'b0;
        @(negedge clk);

        // Reset while WE is low: abandoned without ack, then re-issued.
        @(posedge clk); #1;
        h_req[0] = 1'b1; h_we[0] = 1'b1; h_addr[0] = 8'h40; h_wdata[0] = 8'h99;
        k = 0;
        while (m_we_n[0] !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_wr_reached", 32'(m_we_n[0]), 32'd0);
        reset = 1'b1;
        h_req[0] = 1'b0;
        @(negedge clk);
        chk("rst_wr_we_n", 32'(m_we_n[0]), 32'd1);
        chk("rst_wr_busy", 32'(busy[0]), 32'd0);
        chk("rst_wr_no_ack", 32'({c_ack[0], h_ack[0]}), 32'd0);
        chk("rst_wr_bus_oe", 32'(b_oe[0]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        run_txn(0, 1'b1, 1'b1, 8'h40, 8'h99);
        run_txn(0, 1'b0, 1'b0, 8'h40, 8'h00);

        // Stretched timing instance.
        run_txn(1, 1'b0, 1'b0, 8'h10, 8'h00);
        run_txn(1, 1'b1, 1'b1, 8'h20, 8'h3C);
        run_txn(1, 1'b0, 1'b0, 8'h20, 8'h00);
        run_txn(1, 1'b1, 1'b1, OUTA, 8'h81);

        // Randomized traffic over a small address set, including OUT_ADDR.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 14; n++) begin
                r  = int'($urandom_range(0, 8));
                ra = (r == 8) ? OUTA : 8'(r);
                run_txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
